cd_param: RTL
=============

# cd_param

Parametrised second-generation single-cycle datapath for the small CPU. It is generalised in data width, program-counter width and subroutine depth, and adds a hardware return-address stack for call/return. Instruction fetch is external: the block presents `pc` and consumes `instr` in the same cycle. It sits between the control unit, which drives the select/enable lines and reads `opcode`/`z`, and the program memory.

## Interface
- `DW`, default 8: data/register width; must be ≥ 8.
- `PCW`, default 10: program-counter width; must be ≤ 10.
- `RSD`, default 4: return-stack depth in entries; must be ≥ 1.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `instr`  in  16  instruction word for the current `pc`.
- `s_inc`  in  1  1: next PC = PC+1; 0: next PC = jump target `instr[PCW-1:0]`.
- `s_inm`  in  1  1: write-back data = immediate; 0: write-back data = ALU result.
- `we3`  in  1  register-file write enable.
- `wez`  in  1  zero-flag load enable.
- `op_alu`  in  3  ALU operation.
- `s_call`  in  1  call: push PC+1, jump to `instr[PCW-1:0]`.
- `s_ret`  in  1  return: pop top of stack into PC.
- `pc`  out  PCW  current program counter.
- `opcode`  out  6  `instr[15:10]`.
- `z`  out  1  registered zero flag.
- `stack_err`  out  1  sticky; set on return-stack overflow or underflow.

## Operation
- Instruction fields:
  - `instr[11:8]` = write address.
  - `instr[7:4]` = read address 1.
  - `instr[3:0]` = read address 2.
  - Immediate = `instr[11:4]`, zero-extended to DW.
- Register file: 16 × DW. Two combinational reads, one synchronous write when `we3`=1. Register 0 reads as 0 and ignores writes. Contents are not reset.
- ALU (DW bits, result = A op B, A = rd1, B = rd2):
  - 000 A
  - 001 ~A
  - 010 A+B, carry discarded, wraps mod 2^DW
  - 011 A−B, wraps
  - 100 A&B
  - 101 A|B
  - 110 −A
  - 111 −B
- Zero flag: combinational `zalu` = (result == 0). `z` loads `zalu` on clk when `wez`=1.
- Next-PC priority, highest first:
  - `s_ret`: pop → PC = popped value. `s_call` is ignored if also asserted; no push occurs.
  - `s_call`: push PC+1 (mod 2^PCW) → PC = `instr[PCW-1:0]`.
  - `s_inc`=1: PC+1, wraps from 2^PCW−1 to 0.
  - Otherwise: PC = `instr[PCW-1:0]`.
- Return stack: RSD entries × PCW, pointer `sp` in 0..RSD.
  - Push when `sp`=RSD (full): the write is discarded, `sp` is unchanged, `stack_err` is set, and the jump is still taken.
  - Pop when `sp`=0 (empty): `stack_err` is set, `sp` stays 0, and PC = PC+1, so the return acts as a NOP.
- The datapath does not gate `we3`/`wez` during call/return. The control unit must drive them to 0.
- `stack_err` clears only on reset.

## Timing
- Single-cycle: `pc`, `opcode`, the register reads, the ALU result and `zalu` are combinational within the cycle. PC, register write, `z`, stack and `sp` update on the same rising edge.
- Latency: a written register is readable in the next cycle. A pushed address is poppable in the next cycle.
- Reset, asynchronous and asserted low, applies immediately:
  - `pc`=0, `z`=0, `sp`=0, `stack_err`=0.
  - Stack entry contents are don't-care.
- Reset deassertion is not synchronised internally; it is synchronised upstream.
- Reset during a call or return abandons it: no push or pop survives.

## Configuration
- `CD_RETSTACK_EN` defined: return stack, `s_call`/`s_ret` handling and `stack_err` are present as described above.
- `CD_RETSTACK_EN` undefined: no stack storage or `sp`. `s_call`/`s_ret` are ignored and the PC follows `s_inc` only. `stack_err` is tied to 0. Ports are unchanged.

## Structure
- Shared package `cd_pkg` holds:
  - ALU op localparams (`ALU_A`…`ALU_NEGB`).
  - Instruction field bit positions.
  - Opcode width 6 and instruction width 16.
  - Default DW/PCW/RSD.
- The existing shared register-file, ALU and flip-flop blocks are reused, widened by parameter.
- One new sub-module, `cd_retstack`, is natural. It is parametrised by PCW and RSD and has ports push, pop, din, dout, full, empty and err.

## Test plan
- Reset low mid-run with `pc`=0x05, `z`=1 → `pc`=0, `z`=0, `stack_err`=0 immediately, without waiting for clk.
- Immediate load then add:
  - Setup: `s_inm`=1, `we3`=1, immediate 0x7F into r1; immediate 0x01 into r2.
  - Stimulus: `op_alu`=010, r3 = r1+r2, `wez`=1.
  - DW=8: r3=0x80, `z`=0.
  - Sub r1−r1 → `z`=1.
- Increment wrap: PCW=4, `s_inc`=1 from `pc`=0xF → `pc`=0x0.
- Nested calls, RSD=2:
  - Call at 0x010→0x100, then call at 0x100→0x200.
  - Ret → `pc`=0x101; ret → `pc`=0x011.
  - `stack_err`=0 throughout.
- Overflow/underflow, RSD=1:
  - Two calls → second call still jumps, `stack_err`=1.
  - Reset, then ret with empty stack at `pc`=0x020 → `pc`=0x021, `stack_err`=1.
- `s_call` and `s_ret` together with one entry 0x033 on the stack → `pc`=0x033, `sp`=0, no push.
  - Build without `CD_RETSTACK_EN`: same stimulus → PC follows `s_inc`.

Source files
------------

// File: rtl/cd_pkg.sv
// Shared definitions for the cd_param datapath: instruction layout, ALU op codes
// and default geometry.
package cd_pkg;
  localparam int IW  = 16;
  localparam int OPW = 6;

  localparam int DW_DEF  = 8;
  localparam int PCW_DEF = 10;
  localparam int RSD_DEF = 4;

  // Instruction fields; the immediate overlaps the write address and read address 1
  localparam int OPC_LO = 10;
  localparam int WA_LO  = 8;
  localparam int RA1_LO = 4;
  localparam int RA2_LO = 0;
  localparam int RA_W   = 4;
  localparam int IMM_LO = 4;
  localparam int IMM_W  = 8;

  localparam logic [2:0] ALU_A    = 3'b000;
  localparam logic [2:0] ALU_NOTA = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_NEGA = 3'b110;
  localparam logic [2:0] ALU_NEGB = 3'b111;
endpackage

// File: rtl/cd_retstack.sv
// Return-address stack, RSD entries of PCW bits. Pop wins over push; pushing
// when full or popping when empty leaves sp alone and sets the sticky err.
module cd_retstack #(
  parameter int PCW = 10,
  parameter int RSD = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic           pop,
  input  logic [PCW-1:0] din,
  output logic [PCW-1:0] dout,
  output logic           full,
  output logic           empty,
  output logic           err
);
  localparam int SPW = $clog2(RSD + 1);

  logic [SPW-1:0]          sp;
  logic [RSD-1:0][PCW-1:0] mem;

  assign full  = (sp == SPW'(RSD));
  assign empty = (sp == '0);

  // Top of stack lives at entry sp-1
  always_comb begin
    dout = '0;
    for (int i = 0; i < RSD; i++)
      if (sp == SPW'(i + 1)) dout = mem[i];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < RSD; i++)
      if (push && !pop && !full && sp == SPW'(i)) mem[i] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp  <= '0;
      err <= 1'b0;
    end else if (pop) begin
      if (empty) err <= 1'b1;
      else       sp  <= sp - SPW'(1);
    end else if (push) begin
      if (full)  err <= 1'b1;
      else       sp  <= sp + SPW'(1);
    end
  end
endmodule

// File: rtl/cd_param.sv
// Parametrised single-cycle datapath: 16xDW register file, 8-op ALU, zero flag, PC.
// Return-address stack for call/return is built only when CD_RETSTACK_EN is defined.
module cd_param
  import cd_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int PCW = PCW_DEF,
  parameter int RSD = RSD_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [IW-1:0]  instr,
  input  logic           s_inc,
  input  logic           s_inm,
  input  logic           we3,
  input  logic           wez,
  input  logic [2:0]     op_alu,
  input  logic           s_call,
  input  logic           s_ret,
  output logic [PCW-1:0] pc,
  output logic [OPW-1:0] opcode,
  output logic           z,
  output logic           stack_err
);
  logic [PCW-1:0]  pc_q, pc_inc, target, pc_nxt;
  logic [RA_W-1:0] wa, ra1, ra2;
  logic [DW-1:0]   rd1, rd2, res, wd;
  logic [DW-1:0]   rf [16];
  logic            zalu;

  assign pc     = pc_q;
  assign opcode = instr[OPC_LO +: OPW];
  assign wa     = instr[WA_LO  +: RA_W];
  assign ra1    = instr[RA1_LO +: RA_W];
  assign ra2    = instr[RA2_LO +: RA_W];
  assign target = instr[PCW-1:0];
  assign pc_inc = pc_q + PCW'(1);

  // r0 is hardwired to zero on read; its storage is never written
  assign rd1 = (ra1 == '0) ? '0 : rf[ra1];
  assign rd2 = (ra2 == '0) ? '0 : rf[ra2];

  always_ff @(posedge clk) begin
    if (we3 && wa != '0) rf[wa] <= wd;
  end

  always_comb begin
    res = rd1;
    case (op_alu)
      ALU_A:    res = rd1;
      ALU_NOTA: res = ~rd1;
      ALU_ADD:  res = rd1 + rd2;
      ALU_SUB:  res = rd1 - rd2;
      ALU_AND:  res = rd1 & rd2;
      ALU_OR:   res = rd1 | rd2;
      ALU_NEGA: res = '0 - rd1;
      ALU_NEGB: res = '0 - rd2;
      default:  res = rd1;
    endcase
  end

  assign zalu = (res == '0);
  assign wd   = s_inm ? DW'(instr[IMM_LO +: IMM_W]) : res;

`ifdef CD_RETSTACK_EN
  logic [PCW-1:0] rs_top;
  logic           rs_empty, rs_full_unused;

  cd_retstack #(.PCW(PCW), .RSD(RSD)) u_rs (
    .clk   (clk),
    .reset (reset),
    .push  (s_call & ~s_ret),
    .pop   (s_ret),
    .din   (pc_inc),
    .dout  (rs_top),
    .full  (rs_full_unused),
    .empty (rs_empty),
    .err   (stack_err)
  );

  // A return on an empty stack degrades to a plain increment
  always_comb begin
    pc_nxt = s_inc ? pc_inc : target;
    if (s_call) pc_nxt = target;
    if (s_ret)  pc_nxt = rs_empty ? pc_inc : rs_top;
  end
`else
  logic unused_ctl;
  assign unused_ctl = s_call ^ s_ret;
  assign stack_err  = 1'b0;

  always_comb begin
    pc_nxt = s_inc ? pc_inc : target;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
      z    <= 1'b0;
    end else begin
      pc_q <= pc_nxt;
      if (wez) z <= zalu;
    end
  end
endmodule
